// File: rtl/video_overlay_pkg.sv
// video_overlay_pkg
//   Shared types and constants for the video overlay blocks.
//   - rgb_t                : 24-bit packed pixel {R, G, B}
//   - COLOR_CURSOR_DEFAULT : default cursor colour (bright red)
//   - COLOR_TRAIL_DEFAULT  : default trail colour (dark red), present only
//                            when STEP_CURSOR_TRAIL_EN is defined
//   - line_in_band()       : inclusive line-range test used by overlays
package video_overlay_pkg;

  typedef logic [23:0] rgb_t;

  localparam rgb_t COLOR_CURSOR_DEFAULT = 24'hff0000;
`ifdef STEP_CURSOR_TRAIL_EN
  localparam rgb_t COLOR_TRAIL_DEFAULT  = 24'h800000;
`endif

  // True when line lies in the inclusive band [top, bottom].
  function automatic logic line_in_band(input int line, input int top, input int bottom);
    return (line >= top) && (line <= bottom);
  endfunction

endpackage

// File: rtl/video_line_tracker.sv
// video_line_tracker
//   Tracks the raster position of the incoming video stream.
//   Ports:
//     clock      in   pixel clock, posedge
//     reset_n    in   asynchronous active-low reset
//     de         in   data enable of the incoming stream
//     vsync      in   vertical sync of the incoming stream (active high)
//     column     out  index of the pixel currently on the input (valid while de)
//     line       out  index of the active line currently on the input
//     vsync_rise out  high in the cycle where vsync goes 0 -> 1
//   Column: 0 on the first de-high cycle of a line, +1 per de-high cycle,
//   back to 0 once de is low. Line: +1 on every de falling edge, cleared
//   on the vsync rising edge, saturating at VACTIVE.
module video_line_tracker
  import video_overlay_pkg::*;
#(
  parameter int HACTIVE = 1280,
  parameter int VACTIVE = 720
)(
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         de,
  input  logic                         vsync,
  output logic [$clog2(HACTIVE)-1:0]   column,
  output logic [$clog2(VACTIVE+1)-1:0] line,
  output logic                         vsync_rise
);

  localparam int COL_W  = $clog2(HACTIVE);
  localparam int LINE_W = $clog2(VACTIVE + 1);
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(VACTIVE);

  logic              de_q;
  logic              vsync_q;
  logic              de_fall;
  logic [COL_W-1:0]  col_cnt;
  logic [LINE_W-1:0] line_cnt;

  // Saturating line increment: extra lines past VACTIVE never alias back
  // into the overlay band.
  function automatic logic [LINE_W-1:0] sat_inc(input logic [LINE_W-1:0] v);
    return (v >= LINE_MAX) ? LINE_MAX : v + LINE_W'(1);
  endfunction

  assign vsync_rise = vsync & ~vsync_q;
  assign de_fall    = de_q & ~de;

  // Edge-detect history
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      de_q    <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      de_q    <= de;
      vsync_q <= vsync;
    end
  end

  // Column counter: holds the index of the pixel being presented this cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt <= '0;
    end else if (de) begin
      col_cnt <= col_cnt + COL_W'(1);
    end else begin
      col_cnt <= '0;
    end
  end

  // Line counter: a vsync rise takes priority over a coincident de fall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_cnt <= '0;
    end else if (vsync_rise) begin
      line_cnt <= '0;
    end else if (de_fall) begin
      line_cnt <= sat_inc(line_cnt);
    end
  end

  assign column = col_cnt;
  assign line   = line_cnt;

endmodule

// File: rtl/step_cursor_overlay.sv
// step_cursor_overlay
//   Draws a vertical cursor over a video stream at a column driven by
//   motor step pulses. The working position moves by PIXELS_PER_STEP per
//   pulse and wraps modulo HACTIVE; the displayed column (cursor_x) only
//   takes the working position at a vsync rising edge so a frame never
//   tears. The cursor is drawn on active lines Y_TOP..Y_BOTTOM inclusive.
//   Optional feature macro: STEP_CURSOR_TRAIL_EN -- also draws the
//   previous frame's cursor column in TRAIL_COLOR (cursor wins on overlap).
//   Ports:
//     clock, reset_n                 clock (posedge) and async active-low reset
//     step_pulse, step_dir           one-cycle step strobe, 1 = forward
//     in_video_data/de/hsync/vsync   upstream video
//     video_data/de/hsync/vsync      overlaid video, 1 clock later
//     cursor_x                       column currently displayed
module step_cursor_overlay
  import video_overlay_pkg::*;
#(
  parameter int   HACTIVE         = 1280,
  parameter int   VACTIVE         = 720,
  parameter int   PIXELS_PER_STEP = 20,
  parameter int   Y_TOP           = 100,
  parameter int   Y_BOTTOM        = 220,
  parameter rgb_t CURSOR_COLOR    = COLOR_CURSOR_DEFAULT
`ifdef STEP_CURSOR_TRAIL_EN
  ,
  parameter rgb_t TRAIL_COLOR     = COLOR_TRAIL_DEFAULT
`endif
)(
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       step_pulse,
  input  logic                       step_dir,
  input  rgb_t                       in_video_data,
  input  logic                       in_video_de,
  input  logic                       in_video_hsync,
  input  logic                       in_video_vsync,
  output rgb_t                       video_data,
  output logic                       video_de,
  output logic                       video_hsync,
  output logic                       video_vsync,
  output logic [$clog2(HACTIVE)-1:0] cursor_x
);

  localparam int COL_W  = $clog2(HACTIVE);
  localparam int LINE_W = $clog2(VACTIVE + 1);
  localparam logic [COL_W-1:0] STEP_L = COL_W'(PIXELS_PER_STEP);
  localparam logic [COL_W-1:0] LAST_L = COL_W'(HACTIVE - PIXELS_PER_STEP);

  if (HACTIVE % PIXELS_PER_STEP != 0) begin : g_bad_step
    $error("step_cursor_overlay: HACTIVE must be a multiple of PIXELS_PER_STEP");
  end

  logic [COL_W-1:0]  column;
  logic [LINE_W-1:0] line;
  logic              vsync_rise;
  logic [COL_W-1:0]  pos;
  logic              in_band;
  rgb_t              pix_p0;

  // Wrap-around step of the working position (multiples of the step only).
  function automatic logic [COL_W-1:0] step_pos(input logic [COL_W-1:0] p, input logic fwd);
    if (fwd) begin
      return (p >= LAST_L) ? '0 : p + STEP_L;
    end
    return (p == '0) ? LAST_L : p - STEP_L;
  endfunction

  video_line_tracker #(
    .HACTIVE (HACTIVE),
    .VACTIVE (VACTIVE)
  ) u_tracker (
    .clock      (clock),
    .reset_n    (reset_n),
    .de         (in_video_de),
    .vsync      (in_video_vsync),
    .column     (column),
    .line       (line),
    .vsync_rise (vsync_rise)
  );

  // Working position, free to move at any time
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
    end else if (step_pulse) begin
      pos <= step_pos(pos, step_dir);
    end
  end

  // Displayed position: sampled at frame start. A step in the same cycle
  // lands in pos, so cursor_x gets the pre-step value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cursor_x <= '0;
    end else if (vsync_rise) begin
      cursor_x <= pos;
    end
  end

`ifdef STEP_CURSOR_TRAIL_EN
  logic [COL_W-1:0] trail_x;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trail_x <= '0;
    end else if (vsync_rise) begin
      trail_x <= cursor_x;
    end
  end
`endif

  assign in_band = line_in_band(int'(line), Y_TOP, Y_BOTTOM);

  // Stage p0: pixel select on the incoming beat; cursor assigned last so
  // it overrides the trail.
  always_comb begin
    pix_p0 = in_video_data;
`ifdef STEP_CURSOR_TRAIL_EN
    if (in_video_de && in_band && (column == trail_x)) begin
      pix_p0 = TRAIL_COLOR;
    end
`endif
    if (in_video_de && in_band && (column == cursor_x)) begin
      pix_p0 = CURSOR_COLOR;
    end
  end

  // Stage p0 -> output register: one clock of latency on every signal
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      video_data  <= '0;
      video_de    <= 1'b0;
      video_hsync <= 1'b0;
      video_vsync <= 1'b0;
    end else begin
      video_data  <= pix_p0;
      video_de    <= in_video_de;
      video_hsync <= in_video_hsync;
      video_vsync <= in_video_vsync;
    end
  end

endmodule
